// File: rtl/instruction_memory_pkg.sv
// Shared types and constants for the loadable instruction memory.
package instruction_memory_pkg;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2
  } imem_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/imem_array.sv
// Word storage with one synchronous write port and one synchronous read port.
module imem_array #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 256,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [IDX_W-1:0] raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Contents are not reset here; the owner zeroes them with a clear sweep.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (reset)   rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/instruction_memory_loadable.sv
// Loadable instruction memory: clear sweep after reset, streaming load port, 1-cycle fetch.
// Optional per-word even parity with a sticky error flag when IMEM_PARITY_EN is defined.
module instruction_memory_loadable
  import instruction_memory_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  output logic              load_done,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_ready,
  output logic              instr_valid,
  output logic [DATA_W-1:0] machine_code,
  output logic              fetch_fault,
  output imem_state_e       state
`ifdef IMEM_PARITY_EN
  ,
  output logic              parity_err
`endif
);

  localparam int OFF_W = $clog2(DATA_W / 8);
  localparam int IDX_W = $clog2(DEPTH);
`ifdef IMEM_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif

  logic [IDX_W-1:0]  clear_ptr;
  logic [IDX_W-1:0]  load_ptr;
  logic              accept;
  logic              addr_fault;
  logic              we;
  logic [IDX_W-1:0]  waddr;
  logic [DATA_W-1:0] wdata_word;
  logic [MEM_W-1:0]  wdata;
  logic [IDX_W-1:0]  raddr;
  logic [MEM_W-1:0]  rdata;
  logic              fault_q;
  logic              par_bad;

  assign accept     = fetch_req && fetch_ready;
  assign addr_fault = ((fetch_addr & ADDR_W'(DATA_W / 8 - 1)) != '0) ||
                      ((fetch_addr >> (OFF_W + IDX_W)) != '0);
  assign raddr      = fetch_addr[OFF_W +: IDX_W];

  always_comb begin
    we         = 1'b0;
    waddr      = clear_ptr;
    wdata_word = '0;
    if (state == CLEAR) begin
      we = 1'b1;
    end else if (state == LOAD && load_valid) begin
      we         = 1'b1;
      waddr      = load_ptr;
      wdata_word = load_data;
    end
  end

`ifdef IMEM_PARITY_EN
  logic par_err_q;
  logic par_hit;

  // Stored bit makes the total number of ones even, so a good word XORs to zero.
  assign wdata      = {^wdata_word, wdata_word};
  assign par_bad    = ^rdata;
  assign par_hit    = instr_valid && !fault_q && par_bad;
  assign parity_err = par_err_q || par_hit;

  always_ff @(posedge clk) begin
    if (reset)        par_err_q <= 1'b0;
    else if (par_hit) par_err_q <= 1'b1;
  end
`else
  assign wdata   = wdata_word;
  assign par_bad = 1'b0;
`endif

  imem_array #(
    .WIDTH (MEM_W),
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clk   (clk),
    .reset (reset),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .re    (accept && !addr_fault),
    .raddr (raddr),
    .rdata (rdata)
  );

  // fault_q only updates on an accepted fetch so machine_code holds between responses.
  assign machine_code = (fault_q || par_bad) ? DATA_W'(NOP_INSTR) : rdata[DATA_W-1:0];
  assign fetch_fault  = instr_valid && (fault_q || par_bad);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= CLEAR;
      clear_ptr   <= '0;
      load_ptr    <= '0;
      fetch_ready <= 1'b0;
      load_ready  <= 1'b0;
      load_done   <= 1'b0;
      instr_valid <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      load_done   <= 1'b0;
      instr_valid <= accept;
      if (accept) fault_q <= addr_fault;
      case (state)
        CLEAR: begin
          clear_ptr <= clear_ptr + IDX_W'(1);
          if (clear_ptr == IDX_W'(DEPTH - 1)) begin
            state       <= RUN;
            fetch_ready <= 1'b1;
          end
        end
        RUN: begin
          if (load_start) begin
            state       <= LOAD;
            load_ptr    <= '0;
            fetch_ready <= 1'b0;
            load_ready  <= 1'b1;
          end
        end
        LOAD: begin
          if (load_valid) begin
            load_ptr <= load_ptr + IDX_W'(1);
            if (load_last || load_ptr == IDX_W'(DEPTH - 1)) begin
              state       <= RUN;
              load_ready  <= 1'b0;
              fetch_ready <= 1'b1;
              load_done   <= 1'b1;
            end
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

endmodule
